axi_wr_burst_split: RTL



---
 rtl/axi_wr_burst_split_if.sv | 56 +++++
 rtl/axi_wr_burst_split.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_split_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by both sides of the splitter.
// Ports: aw* address, w* data, b* response; master/slave modports.
interface axi_wr_burst_split_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [AWUSER_WIDTH-1:0] awuser;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STRB_WIDTH-1:0]   wstrb;
    logic                    wlast;
    logic [WUSER_WIDTH-1:0]  wuser;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [BUSER_WIDTH-1:0]  buser;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock,
        output awcache, awprot, awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock,
        input  awcache, awprot, awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_wr_burst_split.sv
// Splits one upstream AXI4 write burst into MAX_BURST_LEN-beat sub-bursts.
// Ports: clk, rst (sync, active-high), s_axi (upstream), m_axi (downstream).
module axi_wr_burst_split #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AWUSER_ENABLE = 0,
    parameter int AWUSER_WIDTH  = 1,
    parameter int WUSER_ENABLE  = 0,
    parameter int WUSER_WIDTH   = 1,
    parameter int BUSER_ENABLE  = 0,
    parameter int BUSER_WIDTH   = 1,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_wr_burst_split_if.slave  s_axi,
    axi_wr_burst_split_if.master m_axi
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RESP} state_t;

    localparam logic [8:0] LP_MAX   = 9'(MAX_BURST_LEN);
    localparam logic [9:0] LP_MAX10 = 10'(MAX_BURST_LEN);

    state_t                  r_state;
    logic [ID_WIDTH-1:0]     r_awid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic [2:0]              r_awsize;
    logic [1:0]              r_awburst;
    logic                    r_awlock;
    logic [3:0]              r_awcache;
    logic [2:0]              r_awprot;
    logic [3:0]              r_awqos;
    logic [3:0]              r_awregion;
    logic [AWUSER_WIDTH-1:0] r_awuser;
    logic                    r_awvalid;
    logic                    r_split;
    logic [8:0]              r_aw_rem;
    logic [8:0]              r_w_rem;
    logic [8:0]              r_w_idx;
    logic [8:0]              r_n_sub;
    logic [8:0]              r_b_cnt;
    logic [1:0]              r_bresp;
    logic [BUSER_WIDTH-1:0]  r_buser;

    logic                  w_split;
    logic [8:0]            w_tot;
    logic [8:0]            w_first;
    logic [8:0]            w_nsub;
    logic [8:0]            w_next_cnt;
    logic [8:0]            w_cur_beats;
    logic [ADDR_WIDTH-1:0] w_size_mask;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_w_act;
    logic                  w_w_hs;
    logic                  w_wlast;
    logic                  w_bready;
    logic                  w_b_hs;
    logic                  w_aw_hs;
    logic                  w_done;
    logic                  w_unused;

    assign w_split = (s_axi.awburst == 2'b01) && !s_axi.awlock
                     && (MAX_BURST_LEN < 256);
    assign w_tot   = {1'b0, s_axi.awlen} + 9'd1;
    assign w_first = (w_split && (w_tot > LP_MAX)) ? LP_MAX : w_tot;
    assign w_nsub  = w_split
                   ? 9'((10'(w_tot) + LP_MAX10 - 10'd1) / LP_MAX10)
                   : 9'd1;

    // r_awaddr/r_awlen always describe the sub-burst currently on AW
    assign w_next_cnt  = (r_aw_rem > LP_MAX) ? LP_MAX : r_aw_rem;
    assign w_cur_beats = {1'b0, r_awlen} + 9'd1;
    assign w_size_mask = (ADDR_WIDTH'(1) << r_awsize) - ADDR_WIDTH'(1);
    assign w_next_addr = (r_awaddr & ~w_size_mask)
                       + (ADDR_WIDTH'(w_cur_beats) << r_awsize);

    assign w_aw_hs  = r_awvalid && m_axi.awready;
    assign w_w_act  = (r_state == ST_ACTIVE) && (r_w_rem != 9'd0) && !rst;
    assign w_w_hs   = w_w_act && s_axi.wvalid && m_axi.wready;
    // an unsplit burst only ends on its final beat
    assign w_wlast  = (r_w_rem == 9'd1)
                   || (r_split && (r_w_idx == LP_MAX - 9'd1));
    assign w_bready = (r_state == ST_ACTIVE) && (r_b_cnt < r_n_sub) && !rst;
    assign w_b_hs   = w_bready && m_axi.bvalid;
    assign w_done   = !r_awvalid && (r_aw_rem == 9'd0)
                   && (r_w_rem == 9'd0) && (r_b_cnt == r_n_sub);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_awvalid  <= 1'b0;
            r_split    <= 1'b0;
            r_aw_rem   <= 9'd0;
            r_w_rem    <= 9'd0;
            r_w_idx    <= 9'd0;
            r_n_sub    <= 9'd0;
            r_b_cnt    <= 9'd0;
            r_bresp    <= 2'd0;
            r_buser    <= '0;
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= 8'd0;
            r_awsize   <= 3'd0;
            r_awburst  <= 2'd0;
            r_awlock   <= 1'b0;
            r_awcache  <= 4'd0;
            r_awprot   <= 3'd0;
            r_awqos    <= 4'd0;
            r_awregion <= 4'd0;
            r_awuser   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (s_axi.awvalid) begin
                        r_awid     <= s_axi.awid;
                        r_awaddr   <= s_axi.awaddr;
                        r_awlen    <= 8'(w_first - 9'd1);
                        r_awsize   <= s_axi.awsize;
                        r_awburst  <= s_axi.awburst;
                        r_awlock   <= s_axi.awlock;
                        r_awcache  <= s_axi.awcache;
                        r_awprot   <= s_axi.awprot;
                        r_awqos    <= s_axi.awqos;
                        r_awregion <= s_axi.awregion;
                        r_awuser   <= s_axi.awuser;
                        r_split    <= w_split;
                        r_aw_rem   <= w_tot - w_first;
                        r_w_rem    <= w_tot;
                        r_w_idx    <= 9'd0;
                        r_n_sub    <= w_nsub;
                        r_b_cnt    <= 9'd0;
                        r_bresp    <= 2'd0;
                        r_awvalid  <= 1'b1;
                        r_state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_aw_hs) begin
                        if (r_aw_rem != 9'd0) begin
                            r_awaddr <= w_next_addr;
                            r_awlen  <= 8'(w_next_cnt - 9'd1);
                            r_aw_rem <= r_aw_rem - w_next_cnt;
                        end else begin
                            r_awvalid <= 1'b0;
                        end
                    end
                    if (w_w_hs) begin
                        r_w_rem <= r_w_rem - 9'd1;
                        r_w_idx <= w_wlast ? 9'd0 : r_w_idx + 9'd1;
                    end
                    if (w_b_hs) begin
                        r_b_cnt <= r_b_cnt + 9'd1;
                        if (m_axi.bresp > r_bresp)
                            r_bresp <= m_axi.bresp;
                        r_buser <= m_axi.buser;
                    end
                    if (w_done)
                        r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (s_axi.bready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi.awready  = (r_state == ST_IDLE) && !rst;

    assign m_axi.awvalid  = r_awvalid;
    assign m_axi.awid     = r_awid;
    assign m_axi.awaddr   = r_awaddr;
    assign m_axi.awlen    = r_awlen;
    assign m_axi.awsize   = r_awsize;
    assign m_axi.awburst  = r_awburst;
    assign m_axi.awlock   = r_awlock;
    assign m_axi.awcache  = r_awcache;
    assign m_axi.awprot   = r_awprot;
    assign m_axi.awqos    = r_awqos;
    assign m_axi.awregion = r_awregion;
    assign m_axi.awuser   = (AWUSER_ENABLE != 0) ? r_awuser : '0;

    assign m_axi.wvalid   = w_w_act && s_axi.wvalid;
    assign s_axi.wready   = w_w_act && m_axi.wready;
    assign m_axi.wdata    = s_axi.wdata;
    assign m_axi.wstrb    = s_axi.wstrb;
    assign m_axi.wlast    = w_w_act && w_wlast;
    assign m_axi.wuser    = (WUSER_ENABLE != 0) ? s_axi.wuser : '0;

    assign m_axi.bready   = w_bready;
    assign s_axi.bvalid   = (r_state == ST_RESP) && !rst;
    assign s_axi.bid      = r_awid;
    assign s_axi.bresp    = r_bresp;
    assign s_axi.buser    = (BUSER_ENABLE != 0) ? r_buser : '0;

    // upstream wlast is regenerated; downstream bid is replaced by awid
    assign w_unused = &{1'b0, s_axi.wlast, m_axi.bid};
endmodule
